mem_lat_ram: RTL and testbench

MEM_LAT_RAM -- requirements
Module: mem_lat_ram

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_lat_array.sv | 46 ++++
 rtl/mem_lat_ram.sv | 130 +++++++++++++
 tb/tb_mem_lat_ram.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the latency-modelled RAM.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // Access sequencer states: idle, counting wait cycles, one-cycle response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lat_array.sv
// Word-organised storage with a byte-enabled core port (combinational read,
// clocked write) and an independent full-word debug port (registered read).
module mem_lat_array
    import mem_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     c_addr,
    input  logic              c_we,
    input  logic [BE_W-1:0]   c_be,
    input  logic [WORD_W-1:0] c_wdata,
    output logic [WORD_W-1:0] c_rdata,
    input  logic [AW-1:0]     d_addr,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata
);

    logic [WORD_W-1:0] mem [0:(2**AW)-1];

    assign c_rdata = mem[c_addr];

    // Storage update: debug write first, core byte writes last so the core wins a collision.
    always_ff @(posedge clk) begin
        if (d_we) begin
            mem[d_addr] <= d_wdata;
        end
        for (int b = 0; b < BE_W; b++) begin
            if (c_we && c_be[b]) begin
                mem[c_addr][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end

    // Debug read register; samples the pre-write contents on a write edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rdata <= '0;
        end else begin
            d_rdata <= mem[d_addr];
        end
    end

endmodule

// File: rtl/mem_lat_ram.sv
// Single-port RAM with a configurable access latency.
// Handshake: a request (i_we|i_re) is taken only while o_busy is low; it is
// answered LAT+1 cycles later by a one-cycle o_ready pulse. Requests seen
// while o_busy is high are dropped, never queued. Read data is loaded into
// o_data on the edge that raises o_ready; writes commit on the edge that
// ends the response cycle.
module mem_lat_ram
    import mem_pkg::*;
#(
    parameter int    WIDTH     = 12,
    parameter int    LAT       = 2,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  i_addr,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [BE_W-1:0]   i_be,
    output logic [WORD_W-1:0] o_data,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_err,
    input  logic [WIDTH-3:0]  i_dbg_addr,
    input  logic              i_dbg_we,
    input  logic [WORD_W-1:0] i_dbg_data,
    output logic [WORD_W-1:0] o_dbg_data
);

    localparam int         AW    = WIDTH - 2;
    localparam logic [3:0] LAT_V = 4'(LAT);

    state_t            state;
    logic [3:0]        cnt;
    logic [AW-1:0]     lat_addr;
    logic [WORD_W-1:0] lat_data;
    logic [BE_W-1:0]   lat_be;
    logic              lat_wr;

    logic              req;
    logic [AW-1:0]     c_addr;
    logic              commit;
    logic [WORD_W-1:0] c_rdata;

    assign req    = i_we | i_re;
    // In IDLE the array is addressed straight from the core so a LAT=0 read
    // can be captured on its acceptance edge; otherwise the latched word.
    assign c_addr = (state == IDLE) ? i_addr[WIDTH-1:2] : lat_addr;
    assign commit = (state == RESP) && lat_wr;

    mem_lat_array #(
        .AW (AW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .c_addr  (c_addr),
        .c_we    (commit),
        .c_be    (lat_be),
        .c_wdata (lat_data),
        .c_rdata (c_rdata),
        .d_addr  (i_dbg_addr),
        .d_we    (i_dbg_we),
        .d_wdata (i_dbg_data),
        .d_rdata (o_dbg_data)
    );

    // Access sequencer with registered ready/busy/err/data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_be   <= '0;
            lat_wr   <= 1'b0;
            o_ready  <= 1'b0;
            o_busy   <= 1'b0;
            o_err    <= 1'b0;
            o_data   <= '0;
        end else begin
            o_ready <= 1'b0;
            o_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_addr <= i_addr[WIDTH-1:2];
                        lat_data <= i_data;
                        lat_be   <= i_be;
                        lat_wr   <= i_we;
                        o_err    <= (i_we & i_re) | (i_addr[1:0] != 2'b00);
                        o_busy   <= 1'b1;
                        if (LAT_V == 4'd0) begin
                            state   <= RESP;
                            cnt     <= '0;
                            o_ready <= 1'b1;
                            if (!i_we) begin
                                o_data <= c_rdata;
                            end
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_V;
                        end
                    end
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        state   <= RESP;
                        cnt     <= '0;
                        o_ready <= 1'b1;
                        if (!lat_wr) begin
                            o_data <= c_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lat_ram.sv
// Directed plus randomized bench for mem_lat_ram (LAT=2 and LAT=0 builds).
module tb_mem_lat_ram;

    logic        clk;
    logic        rst_n;

    // LAT=2 instance
    logic [11:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_we, a_re;
    logic [3:0]  a_be;
    logic [31:0] a_data;
    logic        a_ready, a_busy, a_err;
    logic [9:0]  a_dbg_addr;
    logic        a_dbg_we;
    logic [31:0] a_dbg_wdata, a_dbg_data;

    // LAT=0 instance
    logic [11:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_we, b_re;
    logic [3:0]  b_be;
    logic [31:0] b_data;
    logic        b_ready, b_busy, b_err;
    logic [9:0]  b_dbg_addr;
    logic        b_dbg_we;
    logic [31:0] b_dbg_wdata, b_dbg_data;

    int total;
    int bad;

    logic [31:0] model [0:63];
    logic [31:0] model_b2;
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;

    mem_lat_ram #(.WIDTH(12), .LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_addr(a_addr), .i_data(a_wdata), .i_we(a_we), .i_re(a_re), .i_be(a_be),
        .o_data(a_data), .o_ready(a_ready), .o_busy(a_busy), .o_err(a_err),
        .i_dbg_addr(a_dbg_addr), .i_dbg_we(a_dbg_we), .i_dbg_data(a_dbg_wdata),
        .o_dbg_data(a_dbg_data)
    );

    mem_lat_ram #(.WIDTH(12), .LAT(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_addr(b_addr), .i_data(b_wdata), .i_we(b_we), .i_re(b_re), .i_be(b_be),
        .o_data(b_data), .o_ready(b_ready), .o_busy(b_busy), .o_err(b_err),
        .i_dbg_addr(b_dbg_addr), .i_dbg_we(b_dbg_we), .i_dbg_data(b_dbg_wdata),
        .o_dbg_data(b_dbg_data)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---- driver / check tasks ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dbg_write(input int w, input logic [31:0] d);
        a_dbg_we    = 1'b1;
        a_dbg_addr  = 10'(w);
        a_dbg_wdata = d;
        step();
        a_dbg_we    = 1'b0;
    endtask

    task automatic dbg_read(input int w, output logic [31:0] d);
        a_dbg_addr = 10'(w);
        step();
        d = a_dbg_data;
    endtask

    // Issue one request on the LAT=2 port; returns cycles from acceptance
    // to o_ready and the o_err value seen right after acceptance.
    task automatic core_access(input logic we, input logic re, input logic [11:0] addr,
                               input logic [31:0] d, input logic [3:0] be,
                               output int lat_n, output logic err_seen);
        int n;
        a_we = we; a_re = re; a_addr = addr; a_wdata = d; a_be = be;
        step();
        err_seen = a_err;
        a_we = 1'b0; a_re = 1'b0;
        n = 0;
        while (!a_ready && n < 20) begin
            step();
            n++;
        end
        lat_n = n;
        step();
    endtask

    // ---- stimulus ----
    initial begin
        int          n;
        logic        e;
        logic [31:0] v;
        int          busy_cnt, rdy_cnt;

        total = 0; bad = 0;
        rst_n = 1'b0;
        a_addr = '0; a_wdata = '0; a_we = 1'b0; a_re = 1'b0; a_be = '0;
        a_dbg_addr = '0; a_dbg_we = 1'b0; a_dbg_wdata = '0;
        b_addr = '0; b_wdata = '0; b_we = 1'b0; b_re = 1'b0; b_be = '0;
        b_dbg_addr = '0; b_dbg_we = 1'b0; b_dbg_wdata = '0;

        // reset state
        #1;
        check("rst_ready", 32'(a_ready), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_data", a_data, 32'd0);
        check("rst_dbg", a_dbg_data, 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        #11 rst_n = 1'b1;
        step();

        // preload known contents
        for (int i = 0; i < 64; i++) begin
            model[i] = $urandom;
            dbg_write(i, model[i]);
        end
        model_b2    = 32'hC0DE_0002;
        b_dbg_we    = 1'b1;
        b_dbg_addr  = 10'd2;
        b_dbg_wdata = model_b2;
        step();
        b_dbg_we = 1'b0;

        // debug write then latency-2 read
        model[5] = 32'h1122_3344;
        dbg_write(5, model[5]);
        core_access(1'b0, 1'b1, 12'h014, 32'h0, 4'hF, n, e);
        check("rd_latency", 32'(n), 32'd2);
        check("rd_data", a_data, 32'h1122_3344);
        check("rd_err", 32'(e), 32'd0);
        check("rd_idle_busy", 32'(a_busy), 32'd0);
        last_rd = 32'h1122_3344;

        // byte-enabled write
        core_access(1'b1, 1'b0, 12'h014, 32'hAABB_CCDD, 4'b0101, n, e);
        check("wr_latency", 32'(n), 32'd2);
        check("wr_keeps_odata", a_data, last_rd);
        dbg_read(5, v);
        check("wr_bytes", v, 32'h11BB_33DD);
        model[5] = 32'h11BB_33DD;

        // request during busy is dropped
        a_re = 1'b1; a_addr = 12'h014; a_be = 4'hF;
        step();
        a_re = 1'b0; a_we = 1'b1; a_addr = 12'h024; a_wdata = 32'hDEAD_BEEF;
        busy_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_busy) busy_cnt++;
            if (a_ready) rdy_cnt++;
            step();
            a_we = 1'b0;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd3);
        check("ready_pulses", 32'(rdy_cnt), 32'd1);
        check("busy_rd_data", a_data, model[5]);
        last_rd = model[5];
        dbg_read(9, v);
        check("ignored_wr", v, model[9]);

        // simultaneous write+read, misaligned
        core_access(1'b1, 1'b1, 12'h021, 32'h5A5A_5A5A, 4'hF, n, e);
        check("both_err", 32'(e), 32'd1);
        check("both_latency", 32'(n), 32'd2);
        check("both_err_cleared", 32'(a_err), 32'd0);
        check("both_no_rd", a_data, last_rd);
        model[8] = 32'h5A5A_5A5A;
        dbg_read(8, v);
        check("both_commit", v, model[8]);

        // misaligned read hits the aligned word
        core_access(1'b0, 1'b1, 12'h016, 32'h0, 4'hF, n, e);
        check("misal_err", 32'(e), 32'd1);
        check("misal_data", a_data, model[5]);

        // be=0: read returns full word, write changes nothing but still completes
        core_access(1'b0, 1'b1, 12'h020, 32'h0, 4'h0, n, e);
        check("be0_rd", a_data, model[8]);
        last_rd = model[8];
        core_access(1'b1, 1'b0, 12'h020, 32'hFFFF_FFFF, 4'h0, n, e);
        check("be0_wr_ready", 32'(n), 32'd2);
        dbg_read(8, v);
        check("be0_wr_nochange", v, model[8]);

        // debug write colliding with core commit; debug read sees old value
        a_we = 1'b1; a_addr = 12'h028; a_wdata = 32'h0BAD_F00D; a_be = 4'hF;
        step();
        a_we = 1'b0;
        step();
        step();
        check("coll_ready", 32'(a_ready), 32'd1);
        a_dbg_we = 1'b1; a_dbg_addr = 10'd10; a_dbg_wdata = 32'h1234_5678;
        step();
        a_dbg_we = 1'b0;
        check("rdw_old", a_dbg_data, model[10]);
        model[10] = 32'h0BAD_F00D;
        dbg_read(10, v);
        check("core_wins", v, model[10]);

        // reset during a write's wait phase
        a_we = 1'b1; a_addr = 12'h00C; a_wdata = 32'hCAFE_F00D; a_be = 4'hF;
        step();
        a_we = 1'b0;
        step();
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(a_ready), 32'd0);
        check("mid_rst_busy", 32'(a_busy), 32'd0);
        check("mid_rst_data", a_data, 32'd0);
        check("mid_rst_dbg", a_dbg_data, 32'd0);
        #2 rst_n = 1'b1;
        step();
        step();
        check("post_rst_busy", 32'(a_busy), 32'd0);
        dbg_read(3, v);
        check("rst_discard", v, model[3]);
        core_access(1'b0, 1'b1, 12'h00C, 32'h0, 4'hF, n, e);
        check("post_rst_lat", 32'(n), 32'd2);
        check("post_rst_data", a_data, model[3]);
        last_rd = model[3];

        // LAT=0 back-to-back reads
        b_re = 1'b1; b_addr = 12'h008;
        for (int i = 0; i < 8; i++) begin
            step();
            check("lat0_ready", 32'(b_ready), ((i % 2) == 0) ? 32'd1 : 32'd0);
            if (i == 0) check("lat0_data", b_data, model_b2);
        end
        b_re = 1'b0;
        step();

        // randomized traffic against the reference model
        for (int k = 0; k < 40; k++) begin
            int          op, w, lo;
            logic [3:0]  be;
            logic [31:0] d;
            logic        we, re, exp_err;
            op = $urandom_range(0, 2);
            w  = $urandom_range(0, 63);
            lo = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            be = 4'($urandom_range(0, 15));
            d  = $urandom;
            we = (op != 0);
            re = (op != 1);
            exp_err = (we && re) || (lo != 0);
            if (!we) exp_q.push_back(model[w]);
            core_access(we, re, 12'(w * 4 + lo), d, be, n, e);
            check("rnd_lat", 32'(n), 32'd2);
            check("rnd_err", 32'(e), 32'(exp_err));
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[w][8*b +: 8] = d[8*b +: 8];
            end else if (exp_q.size() > 0) begin
                last_rd = exp_q.pop_front();
            end
            check("rnd_odata", a_data, last_rd);
            w = $urandom_range(0, 63);
            dbg_read(w, v);
            check("rnd_dbg", v, model[w]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
